// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmit frame engine.
// Holds the FSM state encoding, parity-type constants and a frame length helper.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Line bits in one frame: start + data + optional parity + one or two stops.
    function automatic int unsigned frame_bits(input int unsigned data_width,
                                               input logic        par_en,
                                               input logic        stop2);
        return 32'd2 + data_width + {31'd0, par_en} + {31'd0, stop2};
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational even/odd parity over a data word.
// Present only when UART_TX_PARITY_EN is defined; otherwise the file is empty.
`ifdef UART_TX_PARITY_EN
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule
`endif

// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start, LSB-first data, optional parity, 1/2 stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, READY high, waiting for a word
// ST_START  | driving the start bit (0)
// ST_DATA   | driving data bit bit_cnt, LSB first
// ST_PARITY | driving the parity bit of the latched word
// ST_STOP   | driving stop bit(s); READY on the very last cycle
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  READY,
    output logic                  BUSY,
    output logic                  TX_OUT
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    tx_state_t             state, state_nxt;
    logic [CW-1:0]         cyc_cnt, cyc_nxt;
    logic [BW-1:0]         bit_cnt, bit_nxt;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  stop2_reg;
    logic                  parity_bit;
    logic                  bit_end;
    logic                  last_stop;
    logic                  accept;
    logic                  tx_nxt;

`ifdef UART_TX_PARITY_EN
    logic par_en_reg;
    logic par_typ_reg;

    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data    (data_reg),
        .par_typ (par_typ_reg),
        .parity  (parity_bit)
    );
`else
    logic unused_par_inputs;

    assign unused_par_inputs = PAR_EN ^ PAR_TYP;
    assign parity_bit        = 1'b1;
`endif

    assign bit_end   = (cyc_cnt == CYC_LAST);
    // In STOP the bit counter indexes the stop bit: 0 for the first, 1 for the second.
    assign last_stop = (state == ST_STOP) && bit_end && (bit_cnt == BW'(stop2_reg));
    assign READY     = (state == ST_IDLE) || last_stop;
    assign accept    = DATA_VALID && READY;
    assign BUSY      = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        cyc_nxt   = bit_end ? '0 : cyc_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        tx_nxt    = 1'b1;

        case (state)
            ST_IDLE: begin
                cyc_nxt = '0;
                if (accept) state_nxt = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt = ST_DATA;
                    bit_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        state_nxt = par_en_reg ? ST_PARITY : ST_STOP;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        state_nxt = accept ? ST_START : ST_IDLE;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // The line is registered, so it is driven from the state being entered.
        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = data_reg[bit_nxt];
            ST_PARITY: tx_nxt = parity_bit;
            default:   tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            TX_OUT  <= 1'b1;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_nxt;
            bit_cnt <= bit_nxt;
            TX_OUT  <= tx_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_reg  <= '0;
            stop2_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
`endif
        end else if (accept) begin
            data_reg  <= P_DATA;
            stop2_reg <= STOP2;
`ifdef UART_TX_PARITY_EN
            par_en_reg  <= PAR_EN;
            par_typ_reg <= PAR_TYP;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: two instances (1 and 4 clocks per bit)
// checked every cycle against a queue-of-line-bits model, plus literal frame checks.
module tb_uart_tx_frame;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid [2];
    logic [DW-1:0] pdata [2];
    logic          pen   [2];
    logic          ptyp  [2];
    logic          st2   [2];
    logic          ready [2];
    logic          busy  [2];
    logic          tx    [2];

    int checks = 0;
    int errors = 0;

    // Expected line value for the current and every following cycle of each DUT.
    bit mq0[$];
    bit mq1[$];

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) u_dut1 (
        .CLK(clk), .RST(rst_n), .P_DATA(pdata[0]), .DATA_VALID(valid[0]),
        .PAR_EN(pen[0]), .PAR_TYP(ptyp[0]), .STOP2(st2[0]),
        .READY(ready[0]), .BUSY(busy[0]), .TX_OUT(tx[0])
    );

    uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(4)) u_dut4 (
        .CLK(clk), .RST(rst_n), .P_DATA(pdata[1]), .DATA_VALID(valid[1]),
        .PAR_EN(pen[1]), .PAR_TYP(ptyp[1]), .STOP2(st2[1]),
        .READY(ready[1]), .BUSY(busy[1]), .TX_OUT(tx[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Line bits of one frame, bit i is the i-th bit on the wire.
    function automatic void build_frame(input logic [DW-1:0] w, input logic pe, input logic pt,
                                        input logic s2, output logic [15:0] bits, output int n);
        int ones;
        bits = '0;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < DW; i++) begin
            bits[n] = w[i]; n++;
        end
        if (HAS_PAR && pe) begin
            ones = $countones(w);
            bits[n] = ((ones % 2) == 1) ^ pt; n++;
        end
        bits[n] = 1'b1; n++;
        if (s2) begin
            bits[n] = 1'b1; n++;
        end
    endfunction

    logic [15:0] fb;
    int          fn;
    bit          acc0, acc1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq0.delete();
            mq1.delete();
        end else begin
            acc0 = valid[0] && (mq0.size() <= 1);
            acc1 = valid[1] && (mq1.size() <= 1);
            if (mq0.size() > 0) void'(mq0.pop_front());
            if (mq1.size() > 0) void'(mq1.pop_front());
            if (acc0) begin
                build_frame(pdata[0], pen[0], ptyp[0], st2[0], fb, fn);
                for (int i = 0; i < fn; i++) mq0.push_back(fb[i]);
            end
            if (acc1) begin
                build_frame(pdata[1], pen[1], ptyp[1], st2[1], fb, fn);
                for (int i = 0; i < fn; i++)
                    for (int c = 0; c < 4; c++) mq1.push_back(fb[i]);
            end
        end
    end

    always @(negedge clk) begin
        chk("tx_1cpb",    int'(tx[0]),    (mq0.size() > 0) ? int'(mq0[0]) : 1);
        chk("busy_1cpb",  int'(busy[0]),  int'(mq0.size() > 0));
        chk("ready_1cpb", int'(ready[0]), int'(mq0.size() <= 1));
        chk("tx_4cpb",    int'(tx[1]),    (mq1.size() > 0) ? int'(mq1[0]) : 1);
        chk("busy_4cpb",  int'(busy[1]),  int'(mq1.size() > 0));
        chk("ready_4cpb", int'(ready[1]), int'(mq1.size() <= 1));
    end

    // Offers a word and returns just after the edge that accepts it; VALID stays high.
    task automatic send(input int d, input logic [DW-1:0] w, input logic pe,
                        input logic pt, input logic s2);
        bit ok = 1'b0;
        @(negedge clk);
        pdata[d] = w; pen[d] = pe; ptyp[d] = pt; st2[d] = s2; valid[d] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (ready[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else chk("accept_timeout", 0, 1);
    endtask

    task automatic capture(input int d, input int n, input int drop_at, input int swap_at,
                           input logic [DW-1:0] swap_w, output logic [63:0] txv,
                           output int bcnt, output int rcnt, output int hcnt);
        txv = '0; bcnt = 0; rcnt = 0; hcnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            txv[i] = tx[d];
            bcnt += int'(busy[d]);
            rcnt += int'(ready[d]);
            hcnt += int'(tx[d]);
            if (i == swap_at) pdata[d] = swap_w;
            if (i == drop_at) valid[d] = 1'b0;
        end
    endtask

    task automatic rand_run(input int d, input int cycles);
        bit will = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (will || !valid[d]) begin
                valid[d] = ($urandom_range(0, 3) != 0);
                pdata[d] = DW'($urandom);
                pen[d]   = 1'($urandom_range(0, 1));
                ptyp[d]  = 1'($urandom_range(0, 1));
                st2[d]   = 1'($urandom_range(0, 1));
            end
            will = valid[d] && ready[d];
        end
        @(negedge clk);
        valid[d] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] txv;
        int bcnt, rcnt, hcnt;

        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0; pdata[d] = '0; pen[d] = 1'b0; ptyp[d] = 1'b0; st2[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("reset_tx",    int'(tx[0]),    1);
        chk("reset_busy",  int'(busy[0]),  0);
        chk("reset_ready", int'(ready[0]), 1);
        chk("reset_tx4",   int'(tx[1]),    1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5, no parity, one stop bit
        send(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        capture(0, 12, 0, -1, '0, txv, bcnt, rcnt, hcnt);
        chk("a5_frame_bits", int'(txv[9:0]), 'h34A);
        chk("a5_busy_len",   bcnt, 10);
        chk("a5_ready_cnt",  rcnt, 3);

        // 0xA5 with even then odd parity request
        send(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        capture(0, 12, 0, -1, '0, txv, bcnt, rcnt, hcnt);
        chk("a5_even_bit9", int'(txv[9]), HAS_PAR ? 0 : 1);
        chk("a5_even_len",  bcnt, HAS_PAR ? 11 : 10);
        send(0, 8'hA5, 1'b1, 1'b1, 1'b0);
        capture(0, 12, 0, -1, '0, txv, bcnt, rcnt, hcnt);
        chk("a5_odd_bit9", int'(txv[9]), 1);
        chk("a5_odd_len",  bcnt, HAS_PAR ? 11 : 10);

        // 0x01, two stop bits, four clocks per bit
        send(1, 8'h01, 1'b0, 1'b0, 1'b1);
        capture(1, 50, 0, -1, '0, txv, bcnt, rcnt, hcnt);
        chk("cpb4_busy_len",  bcnt, 44);
        chk("cpb4_high_cnt",  hcnt, 18);
        chk("cpb4_first8",    int'(txv[7:0]), 'hF0);
        chk("cpb4_stop_tail", int'(txv[43:36]), 'hFF);

        // back-to-back: 0x3C then 0xC3 with VALID held
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        capture(0, 20, 10, 0, 8'hC3, txv, bcnt, rcnt, hcnt);
        chk("b2b_frame1",   int'(txv[9:0]), 'h278);
        chk("b2b_frame2",   int'(txv[19:10]), 'h386);
        chk("b2b_busy_len", bcnt, 20);
        chk("b2b_ready",    rcnt, 2);
        repeat (3) @(negedge clk);

        // reset during data bit 4 of 0xFF, then a clean 0x55 frame
        send(0, 8'hFF, 1'b0, 1'b0, 1'b0);
        capture(0, 6, 0, -1, '0, txv, bcnt, rcnt, hcnt);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx",    int'(tx[0]),    1);
        chk("midrst_busy",  int'(busy[0]),  0);
        chk("midrst_ready", int'(ready[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        capture(0, 3, -1, -1, '0, txv, bcnt, rcnt, hcnt);
        chk("postrst_idle", bcnt, 0);
        send(0, 8'h55, 1'b0, 1'b0, 1'b0);
        capture(0, 12, 0, -1, '0, txv, bcnt, rcnt, hcnt);
        chk("x55_frame_bits", int'(txv[9:0]), 'h2AA);
        chk("x55_busy_len",   bcnt, 10);

        fork
            rand_run(0, 800);
            rand_run(1, 1600);
        join
        repeat (60) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
